// File: rtl/ram_arbiter_pkg.sv
// Shared state encoding, entry layout and defaults for the main-RAM arbiter.
package ram_arbiter_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam int unsigned AW_DEFAULT   = 16;
    localparam logic [7:0]  FILL_DEFAULT = 8'hFF;

    // Download entry layout for the native 64 KB RAM.
    typedef struct packed {
        logic [AW_DEFAULT-1:0] addr;
        logic [7:0]            data;
    } dl_entry_t;

endpackage

// File: rtl/ram_arbiter_fifo.sv
// Synchronous download write buffer; a push into a full FIFO is accepted when a pop happens in the same cycle.
module ram_arbiter_fifo
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = dl_entry_t
) (
    input  logic   clk_sys,
    input  logic   RESET,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t dout,
    output logic   empty,
    output logic   full,
    output logic   overflow
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Main-RAM sequencer: full clear after reset/request, then CPU vs. buffered download arbitration.
// Build option RAMARB_PATTERN_EN: clear writes 00/FILL in alternating 128-byte blocks instead of all FILL.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW           = AW_DEFAULT,
    parameter logic [7:0]  FILL         = FILL_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          clear_req,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_grant,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_dout,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_full,
    output logic          dl_overflow,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_d,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          clearing
);
    localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_nxt;
    logic [AW-1:0] last_addr;
    logic [7:0]    last_d;
    logic          rvalid_q;
    logic [7:0]    clr_byte;
    entry_t        fifo_din;
    entry_t        fifo_dout;
    logic          fifo_pop;
    logic          fifo_empty;

`ifdef RAMARB_PATTERN_EN
    localparam int unsigned PB = (AW > 7) ? 7 : 0;
    assign clr_byte = ((AW > 7) && clr_cnt[PB]) ? FILL : 8'h00;
`else
    assign clr_byte = FILL;
`endif

    assign fifo_din   = '{addr: dl_addr, data: dl_data};
    assign cpu_rvalid = rvalid_q;
    assign cpu_dout   = ram_q;
    assign clearing   = RESET || (state == CLEAR);

    ram_arbiter_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .RESET    (RESET),
        .push     (dl_wr),
        .pop      (fifo_pop),
        .din      (fifo_din),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (dl_full),
        .overflow (dl_overflow)
    );

    // The RAM port is driven combinationally so a request is issued in the cycle it is granted.
    always_comb begin
        cpu_grant  = 1'b0;
        fifo_pop   = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = last_addr;
        ram_d      = last_d;
        starve_nxt = starve;
        if (RESET) begin
            starve_nxt = starve;
        end else if (state == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt;
            ram_d    = clr_byte;
        end else if (!fifo_empty && (starve == STARVE_MAX)) begin
            fifo_pop   = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = fifo_dout.addr;
            ram_d      = fifo_dout.data;
            starve_nxt = '0;
        end else if (cpu_cs) begin
            cpu_grant  = 1'b1;
            ram_we     = cpu_we;
            ram_addr   = cpu_addr;
            ram_d      = cpu_din;
            starve_nxt = fifo_empty ? '0 :
                         (starve == STARVE_MAX) ? starve : starve + 1'b1;
        end else if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            ram_we     = 1'b1;
            ram_addr   = fifo_dout.addr;
            ram_d      = fifo_dout.data;
            starve_nxt = '0;
        end else begin
            starve_nxt = '0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            starve    <= '0;
            rvalid_q  <= 1'b0;
            last_addr <= '0;
            last_d    <= '0;
        end else begin
            starve   <= starve_nxt;
            rvalid_q <= cpu_grant && !cpu_we;
            if (cpu_grant || ram_we) begin
                last_addr <= ram_addr;
                last_d    <= ram_d;
            end
            case (state)
                CLEAR: begin
                    if (clear_req) begin
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == '1) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter (AW=8): directed tables/sequences plus randomized traffic vs. a queue-based model.
module tb_ram_arbiter;

    localparam int AW    = 8;
    localparam int DEPTH = 4;
    localparam int SL    = 8;
    localparam int NWORD = 1 << AW;

    logic          clk_sys;
    logic          RESET;
    logic          clear_req;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_grant;
    logic          cpu_rvalid;
    logic [7:0]    cpu_dout;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_full;
    logic          dl_overflow;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_d;
    logic          ram_we;
    logic [7:0]    ram_q;
    logic          clearing;

    ram_arbiter #(
        .AW           (AW),
        .FILL         (8'hFF),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .clear_req   (clear_req),
        .cpu_cs      (cpu_cs),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_grant   (cpu_grant),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_dout    (cpu_dout),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_full     (dl_full),
        .dl_overflow (dl_overflow),
        .ram_addr    (ram_addr),
        .ram_d       (ram_d),
        .ram_we      (ram_we),
        .ram_q       (ram_q),
        .clearing    (clearing)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Synchronous single-port RAM array
    logic [7:0] ram [NWORD];
    initial for (int i = 0; i < NWORD; i++) ram[i] = 8'h5A;
    always @(posedge clk_sys) begin
        if (ram_we) ram[ram_addr] <= ram_d;
        ram_q <= ram[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] clr_exp(input int a);
`ifdef RAMARB_PATTERN_EN
        return ((a & 128) != 0) ? 8'hFF : 8'h00;
`else
        return (a >= 0) ? 8'hFF : 8'hFF;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } ent_t;

    ent_t       fq[$];
    bit         m_clr    = 1'b1;
    int         m_cnt    = 0;
    int         m_starve = 0;
    bit         m_ovf    = 1'b0;
    bit         m_rv     = 1'b0;
    logic [7:0] m_rdata  = 8'h00;
    logic [7:0] m_last   = 8'h00;
    logic [7:0] mem_exp [NWORD];
    bit         e_grant, e_we, e_pop;
    logic [7:0] e_addr, e_d;

    initial for (int i = 0; i < NWORD; i++) mem_exp[i] = 8'h5A;

    task automatic model_eval();
        e_grant = 1'b0; e_we = 1'b0; e_pop = 1'b0; e_addr = m_last; e_d = 8'h00;
        if (RESET) begin
            chk("m_rst_grant", cpu_grant, 0);
            chk("m_rst_we", ram_we, 0);
            chk("m_rst_clearing", clearing, 1);
            return;
        end
        if (m_clr) begin
            e_we = 1'b1; e_addr = 8'(m_cnt); e_d = clr_exp(m_cnt);
        end else if (fq.size() > 0 && m_starve == SL) begin
            e_pop = 1'b1; e_we = 1'b1; e_addr = fq[0].addr; e_d = fq[0].data;
        end else if (cpu_cs) begin
            e_grant = 1'b1; e_we = cpu_we; e_addr = cpu_addr; e_d = cpu_din;
        end else if (fq.size() > 0) begin
            e_pop = 1'b1; e_we = 1'b1; e_addr = fq[0].addr; e_d = fq[0].data;
        end
        chk("m_grant", cpu_grant, e_grant);
        chk("m_we", ram_we, e_we);
        chk("m_addr", ram_addr, e_addr);
        if (e_we) chk("m_d", ram_d, e_d);
        chk("m_clearing", clearing, m_clr);
        chk("m_rvalid", cpu_rvalid, m_rv);
        if (m_rv) chk("m_dout", cpu_dout, m_rdata);
        chk("m_full", dl_full, fq.size() == DEPTH);
        chk("m_overflow", dl_overflow, m_ovf);
    endtask

    task automatic model_step();
        int sz;
        if (RESET) begin
            m_clr = 1'b1; m_cnt = 0; fq.delete(); m_ovf = 1'b0;
            m_starve = 0; m_rv = 1'b0; m_last = 8'h00;
            return;
        end
        sz = fq.size();
        m_rv = e_grant && !cpu_we;
        if (m_rv) m_rdata = mem_exp[e_addr];
        if (e_we) mem_exp[e_addr] = e_d;
        if (e_grant || e_we) m_last = e_addr;
        if (e_pop) void'(fq.pop_front());
        if (dl_wr) begin
            if (sz < DEPTH || e_pop) fq.push_back('{dl_addr, dl_data});
            else m_ovf = 1'b1;
        end
        if (!m_clr) begin
            if (e_grant && sz > 0) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
            else m_starve = 0;
        end
        if (m_clr) begin
            if (clear_req) m_cnt = 0;
            else if (m_cnt == NWORD - 1) begin m_clr = 1'b0; m_cnt = 0; end
            else m_cnt++;
        end else if (clear_req) begin
            m_clr = 1'b1; m_cnt = 0;
        end
    endtask

    initial forever begin @(negedge clk_sys); model_eval(); end
    initial forever begin @(posedge clk_sys); model_step(); end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    ent_t got[$];
    int   got_idx[$];

    // Runs idle cycles until idle_need non-clearing cycles have passed, logging RAM writes.
    task automatic run_until_idle(input int idle_need, output int clr_cycles, output bit ok);
        int idle;
        idle = 0; clr_cycles = 0; ok = 1'b0;
        got.delete(); got_idx.delete();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_sys);
            if (clearing) clr_cycles++;
            else begin
                if (ram_we) begin got.push_back('{ram_addr, ram_d}); got_idx.push_back(idle); end
                idle++;
            end
            cyc();
            if (idle == idle_need) begin ok = 1'b1; break; end
        end
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [7:0] exp);
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clk_sys);
        chk({name, "_grant"}, cpu_grant, 1);
        cyc();
        cpu_cs = 1'b0;
        @(negedge clk_sys);
        chk({name, "_rvalid"}, cpu_rvalid, 1);
        chk({name, "_dout"}, cpu_dout, exp);
        cyc();
    endtask

    typedef struct {
        bit         cs;
        bit         we;
        logic [7:0] addr;
        logic [7:0] din;
        bit         e_grant;
        bit         e_we;
        logic [7:0] e_addr;
        bit         e_rv;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vt[10];

    initial begin
        int  n, clr_cyc;
        bit  ok, g_last;

        RESET = 1'b1; clear_req = 1'b0; cpu_cs = 1'b1; cpu_we = 1'b1;
        cpu_addr = '0; cpu_din = '0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;

        // Reset state, with a CPU request pending to show it is ignored
        repeat (2) begin
            @(negedge clk_sys);
            chk("rst_grant", cpu_grant, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_clearing", clearing, 1);
            chk("rst_rvalid", cpu_rvalid, 0);
            cyc();
        end
        RESET = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;

        // Power-up clear: one write per cycle, addresses in order
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_sys);
            if (!clearing) begin cyc(); break; end
            chk("clr_we", ram_we, 1);
            chk("clr_addr", ram_addr, n);
            chk("clr_data", ram_d, clr_exp(n));
            n++;
            cyc();
        end
        chk("clr_len", n, NWORD);

        // CPU table: {cs, we, addr, din, grant, we, ram_addr, rvalid, dout}
        vt[0] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 8'h00};
        vt[1] = '{1, 0, 8'h05, 8'h00, 1, 0, 8'h05, 0, 8'h00};
        vt[2] = '{1, 1, 8'h34, 8'h42, 1, 1, 8'h34, 1, clr_exp(5)};
        vt[3] = '{1, 0, 8'h34, 8'h00, 1, 0, 8'h34, 0, 8'h00};
        vt[4] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h34, 1, 8'h42};
        vt[5] = '{1, 1, 8'h10, 8'h99, 1, 1, 8'h10, 0, 8'h00};
        vt[6] = '{1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 0, 8'h00};
        vt[7] = '{1, 0, 8'h34, 8'h00, 1, 0, 8'h34, 1, 8'h99};
        vt[8] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h34, 1, 8'h42};
        vt[9] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h34, 0, 8'h00};
        for (int i = 0; i < 10; i++) begin
            cpu_cs = vt[i].cs; cpu_we = vt[i].we; cpu_addr = vt[i].addr; cpu_din = vt[i].din;
            @(negedge clk_sys);
            chk("tbl_grant", cpu_grant, vt[i].e_grant);
            chk("tbl_we", ram_we, vt[i].e_we);
            chk("tbl_addr", ram_addr, vt[i].e_addr);
            if (vt[i].e_we) chk("tbl_d", ram_d, vt[i].din);
            chk("tbl_rvalid", cpu_rvalid, vt[i].e_rv);
            if (vt[i].e_rv) chk("tbl_dout", cpu_dout, vt[i].e_dout);
            cyc();
        end
        cpu_cs = 1'b0;

        // Six downloads with the CPU idle: drained one per cycle, in order
        got.delete(); got_idx.delete();
        for (int k = 0; k < 10; k++) begin
            dl_wr = (k < 6); dl_addr = 8'(8'h60 + k); dl_data = 8'(8'hA0 + k);
            @(negedge clk_sys);
            if (ram_we) begin got.push_back('{ram_addr, ram_d}); got_idx.push_back(k); end
            cyc();
        end
        dl_wr = 1'b0;
        chk("dl6_count", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) begin
            chk("dl6_addr", got[i].addr, 8'h60 + i);
            chk("dl6_data", got[i].data, 8'hA0 + i);
            chk("dl6_cycle", got_idx[i], i + 1);
        end
        chk("dl6_overflow", dl_overflow, 0);

        // Starvation limit: 8 CPU grants while the FIFO holds one entry, then one FIFO write
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        dl_wr = 1'b1; dl_addr = 8'h70; dl_data = 8'h5C;
        @(negedge clk_sys);
        chk("stv_first_grant", cpu_grant, 1);
        cyc();
        dl_wr = 1'b0;
        for (int k = 0; k < SL; k++) begin
            @(negedge clk_sys);
            chk("stv_grant", cpu_grant, 1);
            cyc();
        end
        @(negedge clk_sys);
        chk("stv_yield_grant", cpu_grant, 0);
        chk("stv_yield_we", ram_we, 1);
        chk("stv_yield_addr", ram_addr, 8'h70);
        chk("stv_yield_d", ram_d, 8'h5C);
        cyc();
        @(negedge clk_sys);
        chk("stv_resume", cpu_grant, 1);
        cyc();
        cpu_cs = 1'b0;

        // Five downloads during a requested clear: full after four, fifth dropped
        clear_req = 1'b1;
        @(negedge clk_sys);
        chk("ovf_req_clearing", clearing, 0);
        cyc();
        clear_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dl_wr = 1'b1; dl_addr = 8'(8'h90 + i); dl_data = 8'(8'hB0 + i);
            @(negedge clk_sys);
            if (i == 0) chk("ovf_clr_start", ram_addr, 8'h00);
            chk("ovf_clearing", clearing, 1);
            chk("ovf_full", dl_full, (i == 4));
            cyc();
        end
        dl_wr = 1'b0;
        @(negedge clk_sys);
        chk("ovf_sticky", dl_overflow, 1);
        chk("ovf_full_hold", dl_full, 1);
        cyc();
        run_until_idle(8, clr_cyc, ok);
        chk("ovf_drain_timeout", ok, 1);
        chk("ovf_clr_cycles", clr_cyc, NWORD - 6);
        chk("ovf_drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk("ovf_drain_addr", got[i].addr, 8'h90 + i);
            chk("ovf_drain_data", got[i].data, 8'hB0 + i);
            chk("ovf_drain_cycle", got_idx[i], i);
        end
        chk("ovf_still_set", dl_overflow, 1);

        // clear_req mid-download, then a restart mid-clear; queued entries land afterwards
        clear_req = 1'b1; dl_wr = 1'b1; dl_addr = 8'hC0; dl_data = 8'hD0;
        cyc();
        clear_req = 1'b0;
        for (int i = 1; i < 3; i++) begin
            dl_addr = 8'(8'hC0 + i); dl_data = 8'(8'hD0 + i);
            @(negedge clk_sys);
            if (i == 1) chk("mid_clr_start", ram_addr, 8'h00);
            cyc();
        end
        dl_wr = 1'b0;
        repeat (98) cyc();
        clear_req = 1'b1;
        @(negedge clk_sys);
        chk("mid_restart_cnt", ram_addr, 8'd100);
        cyc();
        clear_req = 1'b0;
        @(negedge clk_sys);
        chk("mid_restart_addr", ram_addr, 8'h00);
        chk("mid_restart_clearing", clearing, 1);
        cyc();
        run_until_idle(6, clr_cyc, ok);
        chk("mid_drain_timeout", ok, 1);
        chk("mid_clr_cycles", clr_cyc, NWORD - 1);
        chk("mid_drain_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) begin
            chk("mid_drain_addr", got[i].addr, 8'hC0 + i);
            chk("mid_drain_data", got[i].data, 8'hD0 + i);
        end
        rd("pat80", 8'h80, clr_exp(8'h80));
        rd("pat00", 8'h00, clr_exp(8'h00));
        rd("patC1", 8'hC1, 8'hD1);

        // Reset clears the sticky overflow
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        @(negedge clk_sys);
        chk("rst2_overflow", dl_overflow, 0);
        chk("rst2_full", dl_full, 0);
        chk("rst2_addr", ram_addr, 8'h00);
        cyc();
        run_until_idle(2, clr_cyc, ok);
        chk("rst2_timeout", ok, 1);

        // Randomized traffic against the model; a CPU request is held until granted
        g_last = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!cpu_cs || g_last) begin
                cpu_cs   = ($urandom_range(0, 3) != 0);
                cpu_we   = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom);
                cpu_din  = 8'($urandom);
            end
            dl_wr     = ($urandom_range(0, 9) < 3);
            dl_addr   = 8'($urandom);
            dl_data   = 8'($urandom);
            clear_req = ($urandom_range(0, 999) == 0);
            @(negedge clk_sys);
            g_last = cpu_grant;
            cyc();
        end
        cpu_cs = 1'b0; dl_wr = 1'b0; clear_req = 1'b0;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Owns the single-port 64 KB main system RAM and sequences every access to it.
- Runs a full-memory clear after reset or on request.
- Arbitrates between the CPU port and a buffered ioctl download port that writes into RAM.
- Sits between hps_io/loader logic, the machine core and the RAM array. Replaces ad-hoc clear and mux logic.

Parameters:
- AW, 16, RAM address width (2^AW bytes).
- FILL, 8'hFF, byte written during clear.
- FIFO_DEPTH, 4, download write buffer entries (power of 2, >=2).
- STARVE_LIMIT, 8, maximum consecutive CPU grants while the FIFO is non-empty.

Ports:
- clk_sys  in  1  system clock
- RESET  in  1  synchronous active-high reset
- clear_req  in  1  one-cycle pulse; restart the full clear
- cpu_cs  in  1  CPU access request; held until granted
- cpu_we  in  1  1 = write
- cpu_addr  in  AW  CPU address
- cpu_din  in  8  CPU write data
- cpu_grant  out  1  access is issued to RAM this cycle
- cpu_rvalid  out  1  cpu_dout is valid (read issued one cycle earlier)
- cpu_dout  out  8  read data
- dl_wr  in  1  download write strobe
- dl_addr  in  AW  download address
- dl_data  in  8  download data
- dl_full  out  1  FIFO full
- dl_overflow  out  1  sticky; a download write was dropped
- ram_addr  out  AW  RAM address
- ram_d  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM read data (synchronous, 1-cycle latency)
- clearing  out  1  clear in progress

Behaviour:
- Reset (RESET=1):
  - State becomes CLEAR, clear counter 0.
  - FIFO emptied; dl_overflow=0; starve counter 0.
  - cpu_grant=0, cpu_rvalid=0, ram_we=0, clearing=1.
- CLEAR state:
  - Each cycle: ram_addr=counter, ram_d=FILL, ram_we=1, counter+1.
  - After writing address 2^AW-1, go to RUN. Clear takes exactly 2^AW cycles; clearing drops the cycle after the last write.
  - cpu_grant held 0.
  - dl_wr still pushes into the FIFO; the FIFO is not drained.
- clear_req in RUN: the next cycle enters CLEAR with counter 0. FIFO contents are kept.
- clear_req in CLEAR: counter restarts at 0.
- RUN state, per-cycle priority:
  - If FIFO non-empty and starve count = STARVE_LIMIT, pop the FIFO (ram_we=1 with the entry's address/data). cpu_grant=0, starve count 0.
  - Otherwise, if cpu_cs: cpu_grant=1; ram_addr=cpu_addr, ram_d=cpu_din, ram_we=cpu_we. Starve count +1 if FIFO non-empty, else 0.
  - Otherwise, if FIFO non-empty: pop the FIFO; starve count 0.
  - Otherwise: ram_we=0, ram_addr holds its last value.
- Read return: cpu_rvalid=1 exactly one cycle after a granted read (cpu_we=0); cpu_dout=ram_q in that cycle. A granted write never produces rvalid.
- Back-to-back CPU reads are allowed: one per cycle, rvalid pipelined.
- Download FIFO:
  - dl_wr pushes {dl_addr, dl_data}.
  - Push and pop in the same cycle when full: accepted, no overflow.
  - dl_wr while full with no pop: entry dropped, dl_overflow=1 until RESET.
  - dl_full is combinational from the count.
- Write ordering: FIFO entries reach RAM in push order. CPU and download writes to the same address have no ordering guarantee.
- Counters wrap at their widths. The starve counter saturates at STARVE_LIMIT.

Optional Feature:
- Macro RAMARB_PATTERN_EN.
- Defined: the clear byte is 8'h00 when clear-counter bit 7 = 0 and FILL when bit 7 = 1. This reproduces the 128-byte alternating power-up pattern some software relies on.
- Undefined: every byte is FILL. The port list is identical in both builds.

Decomposition:
- Package ram_arbiter_pkg: state enum (CLEAR, RUN), FIFO entry struct {addr[AW], data[8]}, default FILL constant.
- One sub-module, ram_arbiter_fifo: synchronous FIFO with count, full, empty and a same-cycle push/pop rule.
- Arbitration, clear FSM and the rvalid pipeline stay in ram_arbiter.

Test Plan:
- Reset, AW=4: exactly 16 writes of 8'hFF to addresses 0..15; clearing falls on cycle 16; read of address 5 gives cpu_rvalid one cycle after grant with cpu_dout=8'hFF.
- RUN, CPU writes 8'h42 to 16'h1234 then reads it back: grant same cycle as cs, rvalid next cycle, dout=8'h42.
- 6 dl_wr strobes while CPU is idle: all reach RAM in order, one per cycle; dl_overflow stays 0.
- cpu_cs held continuously with 1 FIFO entry, STARVE_LIMIT=8: 8 CPU grants, then one cycle with grant=0 and the FIFO write, then CPU resumes.
- 5 dl_wr strobes during CLEAR with FIFO_DEPTH=4: dl_full after 4, dl_overflow=1; after clear, 4 entries are drained.
- clear_req mid-download: refill restarts from address 0; queued FIFO entries are written after the clear. With RAMARB_PATTERN_EN, address 16'h0080 reads FF and 16'h0000 reads 00.
